// File: rtl/dbx_plane_assembler.sv
// dbx_plane_assembler: undoes the DBX XOR chain over DATA_W+1 serial planes and holds the block for downstream.
// Optional second block register (skid slot) enabled by defining DBX_ASM_DOUBLE_BUF_EN.
//
// state   | meaning
// IDLE    | waiting for the base word of the next block
// COLLECT | accepting DBX planes, counter walks DATA_W down to 0
// FULL    | block presented on the outputs until rdy_i (single-slot build only)
module dbx_plane_assembler #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  input  logic [DATA_W-1:0]                     base_i,
  input  logic                                  base_vld_i,
  output logic                                  base_rdy_o,
  input  logic [BLOCK_SIZE-2:0]                 plane_i,
  input  logic                                  plane_vld_i,
  output logic                                  plane_rdy_o,
  output logic [DATA_W-1:0]                     base_o,
  output logic [(DATA_W+1)*(BLOCK_SIZE-1)-1:0]  dbp_o,
  output logic                                  vld_o,
  input  logic                                  rdy_i
);

  localparam int PW = BLOCK_SIZE - 1;
  localparam int NP = DATA_W + 1;
  localparam int DW = NP * PW;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [DATA_W-1:0] wrk_base;
  logic [DW-1:0]   wrk_dbp;
  logic [DW-1:0]   wrk_nxt;
  logic [PW-1:0]   dbp_k;
  logic            hs_base;
  logic            hs_plane;

`ifdef DBX_ASM_DOUBLE_BUF_EN
  logic [DATA_W-1:0] skid_base;
  logic [DW-1:0]     skid_dbp;
  logic              skid_vld;
`endif

  assign hs_base  = base_vld_i && base_rdy_o;
  assign hs_plane = plane_vld_i && plane_rdy_o;
  assign dbp_k    = plane_i ^ acc;

  // Working block with the current plane merged in, so the final plane can go straight to the outputs.
  always_comb begin
    wrk_nxt = wrk_dbp;
    for (int k = 0; k < NP; k++) begin
      if (cnt == CW'(k)) wrk_nxt[k*PW +: PW] = dbp_k;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      wrk_base    <= '0;
      wrk_dbp     <= '0;
      base_o      <= '0;
      dbp_o       <= '0;
      vld_o       <= 1'b0;
      base_rdy_o  <= !rst_i;
      plane_rdy_o <= 1'b0;
`ifdef DBX_ASM_DOUBLE_BUF_EN
      skid_base   <= '0;
      skid_dbp    <= '0;
      skid_vld    <= 1'b0;
`endif
    end else begin
`ifdef DBX_ASM_DOUBLE_BUF_EN
      // Consumption refills the output from the skid slot; later assignments below may override.
      if (rdy_i && vld_o) begin
        base_o   <= skid_base;
        dbp_o    <= skid_dbp;
        vld_o    <= skid_vld;
        skid_vld <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (hs_base) begin
            wrk_base    <= base_i;
            cnt         <= CW'(DATA_W);
            acc         <= '0;
            state       <= COLLECT;
            base_rdy_o  <= 1'b0;
            plane_rdy_o <= 1'b1;
          end else begin
`ifdef DBX_ASM_DOUBLE_BUF_EN
            base_rdy_o <= !(vld_o && skid_vld && !rdy_i);
`else
            base_rdy_o <= 1'b1;
`endif
          end
        end
        COLLECT: begin
          if (hs_plane) begin
            acc     <= dbp_k;
            wrk_dbp <= wrk_nxt;
            if (cnt == '0) begin
              plane_rdy_o <= 1'b0;
`ifdef DBX_ASM_DOUBLE_BUF_EN
              state <= IDLE;
              if (!vld_o || (rdy_i && !skid_vld)) begin
                base_o     <= wrk_base;
                dbp_o      <= wrk_nxt;
                vld_o      <= 1'b1;
                base_rdy_o <= 1'b1;
              end else begin
                skid_base  <= wrk_base;
                skid_dbp   <= wrk_nxt;
                skid_vld   <= 1'b1;
                base_rdy_o <= 1'b0;
              end
`else
              state  <= FULL;
              base_o <= wrk_base;
              dbp_o  <= wrk_nxt;
              vld_o  <= 1'b1;
`endif
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        FULL: begin
          if (rdy_i) begin
            state      <= IDLE;
            vld_o      <= 1'b0;
            acc        <= '0;
            base_rdy_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbx_plane_assembler.sv
// Scoreboard bench for dbx_plane_assembler: stimulus pushes hand-computed blocks, a monitor checks each consumed block.
module tb_dbx_plane_assembler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic [7:0]  base_i = '0;
  logic        base_vld_i = 1'b0;
  logic        base_rdy_o;
  logic [6:0]  plane_i = '0;
  logic        plane_vld_i = 1'b0;
  logic        plane_rdy_o;
  logic [7:0]  base_o;
  logic [62:0] dbp_o;
  logic        vld_o;
  logic        rdy_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  b;
    logic [62:0] d;
  } exp_t;
  exp_t exp_q[$];

  dbx_plane_assembler #(.DATA_W(8), .BLOCK_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .base_i(base_i), .base_vld_i(base_vld_i), .base_rdy_o(base_rdy_o),
    .plane_i(plane_i), .plane_vld_i(plane_vld_i), .plane_rdy_o(plane_rdy_o),
    .base_o(base_o), .dbp_o(dbp_o), .vld_o(vld_o), .rdy_i(rdy_i)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [62:0] act, input logic [62:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: a block is checked at the cycle downstream consumes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_o && rdy_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_block", {55'd0, base_o}, 63'h7FFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("blk_base", {55'd0, base_o}, {55'd0, e.b});
          chk("blk_dbp", dbp_o, e.d);
        end
      end
    end
  end

  task automatic send_base(input logic [7:0] b);
    int t = 0;
    base_i = b;
    base_vld_i = 1'b1;
    forever begin
      @(negedge clk);
      if (base_rdy_o) break;
      t++;
      if (t > 300) begin
        chk("base_rdy_timeout", 63'd0, 63'd1);
        break;
      end
    end
    @(posedge clk); #1;
    base_vld_i = 1'b0;
  endtask

  task automatic send_plane(input logic [6:0] p, input bit lat);
    int t = 0;
    plane_i = p;
    plane_vld_i = 1'b1;
    forever begin
      @(negedge clk);
      if (plane_rdy_o) break;
      t++;
      if (t > 300) begin
        chk("plane_rdy_timeout", 63'd0, 63'd1);
        break;
      end
    end
    if (lat) chk("vld_before_last", {62'd0, vld_o}, 63'd0);
    @(posedge clk); #1;
    plane_vld_i = 1'b0;
  endtask

  // pl holds plane k at bits [k*7 +: 7]; ed is the hand-computed DBP result.
  task automatic send_block(input logic [7:0] b, input logic [62:0] pl, input logic [62:0] ed,
                            input bit push, input bit lat);
    send_base(b);
    for (int k = 8; k >= 0; k--) send_plane(pl[k*7 +: 7], lat && (k == 0));
    if (lat) chk("vld_latency", {62'd0, vld_o}, 63'd1);
    if (push) exp_q.push_back('{b: b, d: ed});
  endtask

  task automatic wait_vld();
    int t = 0;
    forever begin
      @(negedge clk);
      if (vld_o) break;
      t++;
      if (t > 300) begin
        chk("vld_timeout", 63'd0, 63'd1);
        break;
      end
    end
  endtask

  task automatic pulse_rdy();
    wait_vld();
    @(posedge clk); #1;
    rdy_i = 1'b1;
    @(posedge clk); #1;
    rdy_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_base_rdy", {62'd0, base_rdy_o}, 63'd0);
    chk("rst_plane_rdy", {62'd0, plane_rdy_o}, 63'd0);
    chk("rst_vld", {62'd0, vld_o}, 63'd0);
    chk("rst_dbp", dbp_o, 63'd0);
    chk("rst_base", {55'd0, base_o}, 63'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_base_rdy", {62'd0, base_rdy_o}, 63'd1);

`ifdef DBX_ASM_DOUBLE_BUF_EN
    send_block(8'hA1, {7'h7F, 56'd0}, {9{7'h7F}}, 1'b1, 1'b1);
    send_block(8'hA2, {56'd0, 7'h40}, {56'd0, 7'h40}, 1'b1, 1'b0);
    @(negedge clk);
    chk("dbl_base_rdy_full", {62'd0, base_rdy_o}, 63'd0);
    chk("dbl_vld_held", {62'd0, vld_o}, 63'd1);
    fork
      send_block(8'hA3, {7'h01, 56'd0}, {9{7'h01}}, 1'b1, 1'b0);
      begin
        repeat (5) @(negedge clk);
        chk("dbl_still_blocked", {62'd0, base_rdy_o}, 63'd0);
        pulse_rdy();
        @(negedge clk);
        chk("dbl_vld_cont1", {62'd0, vld_o}, 63'd1);
      end
    join
    pulse_rdy();
    @(negedge clk);
    chk("dbl_vld_cont2", {62'd0, vld_o}, 63'd1);
    pulse_rdy();
    @(negedge clk);
    chk("dbl_vld_drained", {62'd0, vld_o}, 63'd0);
`else
    // Zero block
    send_block(8'h10, 63'd0, 63'd0, 1'b1, 1'b1);
    pulse_rdy();

    // XOR chain, all seven diffs -1; with backpressure
    send_block(8'h05, {7'h7F, 56'd0}, {9{7'h7F}}, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_dbp_stable", dbp_o, {9{7'h7F}});
      chk("bp_base_stable", {55'd0, base_o}, 63'h05);
      chk("bp_rdys", {61'd0, base_rdy_o, plane_rdy_o}, 63'd0);
    end
    pulse_rdy();
    chk("bp_vld_after_rdy", {62'd0, vld_o}, 63'd0);
    chk("bp_base_rdy_after", {62'd0, base_rdy_o}, 63'd1);

    // Single plane0 diff +1 for word 1
    send_block(8'h05, {56'd0, 7'h40}, {56'd0, 7'h40}, 1'b1, 1'b1);
    pulse_rdy();

    // Two cancelling top planes, then a mid-chain change
    send_block(8'h77, {7'h55, 7'h55, 49'd0}, {7'h55, 56'd0}, 1'b1, 1'b1);
    pulse_rdy();
    send_block(8'h3C, {7'h01, 7'h00, 7'h00, 7'h00, 7'h03, 28'd0},
               {7'h01, 7'h01, 7'h01, 7'h01, 7'h02, 7'h02, 7'h02, 7'h02, 7'h02}, 1'b1, 1'b1);
    pulse_rdy();

    // Flush after four planes, with a plane offered in the clr cycle
    send_base(8'h33);
    for (int k = 0; k < 4; k++) send_plane(7'h7F, 1'b0);
    plane_i = 7'h7F;
    plane_vld_i = 1'b1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    plane_vld_i = 1'b0;
    chk("clr_base_rdy", {62'd0, base_rdy_o}, 63'd1);
    chk("clr_plane_rdy", {62'd0, plane_rdy_o}, 63'd0);
    chk("clr_vld", {62'd0, vld_o}, 63'd0);
    chk("clr_dbp", dbp_o, 63'd0);
    send_block(8'h22, {7'h01, 56'd0}, {9{7'h01}}, 1'b1, 1'b1);
    pulse_rdy();

    // Reset while FULL, block dropped
    send_block(8'h44, {7'h7F, 56'd0}, {9{7'h7F}}, 1'b0, 1'b1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("fullrst_vld", {62'd0, vld_o}, 63'd0);
    chk("fullrst_dbp", dbp_o, 63'd0);
    chk("fullrst_base_rdy", {62'd0, base_rdy_o}, 63'd0);
    rst_i = 1'b0;
    send_block(8'h66, {7'h00, 7'h12, 49'd0}, {7'h00, {8{7'h12}}}, 1'b1, 1'b1);
    pulse_rdy();
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 63'(exp_q.size()), 63'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
